// File: rtl/rifl_rx_deframer.sv
// -----------------------------------------------------------------------------
// rifl_rx_deframer
//   Receive-side frame decoder for a RIFL lane. Takes descrambled frames
//   (4-bit header, payload, CRC), tracks link state (DOWN/UP/ERROR), and
//   pushes data payloads into a first-word-fall-through FIFO that feeds an
//   AXI4-Stream master. Control frames drive remote pause and retransmit
//   indications.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   s_frame_data            frame: [FW-1:FW-4] header, [FW-5:CRC_WIDTH]
//                           payload, [CRC_WIDTH-1:0] CRC (checked upstream)
//   s_frame_valid           frame strobe (no backpressure)
//   s_frame_crc_ok          upstream CRC check result for this frame
//   s_aligned               lane frame alignment achieved
//   m_axis_*                AXI4-Stream output (tdata/tkeep/tlast/tvalid/tready)
//   rx_up                   link is in UP state
//   rx_error                one-cycle pulse on a bad frame or FIFO overflow
//   overflow                sticky FIFO overflow flag
//   pause_req               remote PAUSE in effect
//   local_pause             FIFO nearly full (count >= FIFO_DEPTH-2)
//   retrans_req, retrans_id one-cycle retransmit request and requested frame ID
// -----------------------------------------------------------------------------
module rifl_rx_deframer #(
   parameter int FRAME_WIDTH    = 256,
   parameter int CRC_WIDTH      = 12,
   parameter int FRAME_ID_WIDTH = 8,
   parameter int FIFO_DEPTH     = 8,
   parameter int PAUSE_HOLD     = 16
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [FRAME_WIDTH-1:0]                 s_frame_data,
   input  logic                                   s_frame_valid,
   input  logic                                   s_frame_crc_ok,
   input  logic                                   s_aligned,
   output logic [FRAME_WIDTH-CRC_WIDTH-5:0]       m_axis_tdata,
   output logic [(FRAME_WIDTH-CRC_WIDTH-4)/8-1:0] m_axis_tkeep,
   output logic                                   m_axis_tlast,
   output logic                                   m_axis_tvalid,
   input  logic                                   m_axis_tready,
   output logic                                   rx_up,
   output logic                                   rx_error,
   output logic                                   overflow,
   output logic                                   pause_req,
   output logic                                   local_pause,
   output logic                                   retrans_req,
   output logic [FRAME_ID_WIDTH-1:0]              retrans_id
);

   localparam int PW     = FRAME_WIDTH - 4 - CRC_WIDTH;
   localparam int KW     = PW / 8;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int HOLD_W = $clog2(PAUSE_HOLD + 1);

   localparam logic [3:0] HDR_DATA  = 4'hA;
   localparam logic [3:0] HDR_LAST  = 4'hB;
   localparam logic [3:0] HDR_PART  = 4'hC;
   localparam logic [3:0] HDR_IDLE  = 4'h5;
   localparam logic [3:0] HDR_PAUSE = 4'h6;
   localparam logic [3:0] HDR_RETX  = 4'h9;

   typedef struct packed {
      logic [PW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   typedef enum logic [1:0] {ST_DOWN = 2'd0, ST_UP = 2'd1, ST_ERR = 2'd2} state_t;

   state_t                    state_q, state_d;
   logic [3:0]                hdr;
   logic [PW-1:0]             payload;
   logic [7:0]                part_k;
   logic                      is_data, hdr_bad, k_ok, frame_bad, active, ctl_ok;
   logic                      take, push, pop, full, drop;
   beat_t                     wr_beat, rd_beat;
   beat_t                     mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [HOLD_W-1:0]         hold_q, hold_d;
   logic                      rx_error_q, rx_error_d, overflow_q, overflow_d;
   logic                      pause_q, pause_d, lpause_q, lpause_d;
   logic                      rreq_q, rreq_d;
   logic [FRAME_ID_WIDTH-1:0] rid_q, rid_d;
   logic                      unused_crc;

   // Frame field extraction. The CRC was already checked upstream.
   assign hdr        = s_frame_data[FRAME_WIDTH-1 -: 4];
   assign payload    = s_frame_data[FRAME_WIDTH-5 -: PW];
   assign part_k     = payload[7:0];
   assign unused_crc = ^s_frame_data[CRC_WIDTH-1:0];

   always_comb begin
      is_data = 1'b0;
      hdr_bad = 1'b0;
      case (hdr)
         HDR_DATA, HDR_LAST, HDR_PART: is_data = 1'b1;
         HDR_IDLE, HDR_PAUSE, HDR_RETX: ;
         default: hdr_bad = 1'b1;
      endcase
   end

   // A partial frame must keep at least one byte and fewer than a full beat.
   assign k_ok      = (part_k != 8'd0) && ({24'd0, part_k} < 32'(KW));
   assign frame_bad = !s_frame_crc_ok || hdr_bad || ((hdr == HDR_PART) && !k_ok);
   // Losing alignment overrides the current state, so nothing is acted on.
   assign active    = s_aligned && (state_q != ST_DOWN);
   assign ctl_ok    = s_frame_valid && s_frame_crc_ok && active;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_DOWN;
      else        state_q <= state_d;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      if (!s_aligned) begin
         state_d = ST_DOWN;
      end else if (s_frame_valid) begin
         case (state_q)
            ST_DOWN: if (s_frame_crc_ok && hdr == HDR_IDLE) state_d = ST_UP;
            ST_UP:   if (frame_bad) state_d = ST_ERR;
            ST_ERR:  if (s_frame_crc_ok && hdr == HDR_IDLE) state_d = ST_UP;
            default: state_d = ST_DOWN;
         endcase
      end
   end

   // ---------------- outputs / datapath ----------------
   always_comb begin
      pop  = m_axis_tvalid && m_axis_tready;
      full = (cnt_q == CNT_W'(FIFO_DEPTH));
      take = s_frame_valid && s_aligned && (state_q == ST_UP) && !frame_bad && is_data;
      // A full FIFO can still accept when the head leaves in the same cycle.
      push = take && (!full || pop);
      drop = take && full && !pop;

      wr_beat.data = payload;
      wr_beat.last = (hdr != HDR_DATA);
      wr_beat.keep = (hdr == HDR_PART) ? ~({KW{1'b1}} >> part_k) : {KW{1'b1}};

      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      lpause_d = (cnt_d >= CNT_W'(FIFO_DEPTH - 2));

      rx_error_d = (s_frame_valid && s_aligned && (state_q == ST_UP) && frame_bad) || drop;
      overflow_d = overflow_q || drop;

      rreq_d = ctl_ok && (hdr == HDR_RETX);
      rid_d  = rreq_d ? payload[FRAME_ID_WIDTH-1:0] : rid_q;

      // pause_req stays up while the hold counter is still non-zero, so a
      // single PAUSE yields PAUSE_HOLD+1 cycles of pause_req.
      if (!active) begin
         hold_d  = '0;
         pause_d = 1'b0;
      end else if (ctl_ok && hdr == HDR_PAUSE) begin
         hold_d  = HOLD_W'(PAUSE_HOLD);
         pause_d = 1'b1;
      end else begin
         pause_d = (hold_q != '0);
         hold_d  = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         hold_q     <= '0;
         rx_error_q <= 1'b0;
         overflow_q <= 1'b0;
         pause_q    <= 1'b0;
         lpause_q   <= 1'b0;
         rreq_q     <= 1'b0;
         rid_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         rx_error_q <= rx_error_d;
         overflow_q <= overflow_d;
         pause_q    <= pause_d;
         lpause_q   <= lpause_d;
         rreq_q     <= rreq_d;
         rid_q      <= rid_d;
      end
   end

   // Storage needs no reset: outputs are gated by tvalid, derived from cnt_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_beat;
   end

   assign rd_beat       = mem_q[rd_ptr_q];
   assign m_axis_tvalid = (cnt_q != '0);
   assign m_axis_tdata  = m_axis_tvalid ? rd_beat.data : '0;
   assign m_axis_tkeep  = m_axis_tvalid ? rd_beat.keep : '0;
   assign m_axis_tlast  = m_axis_tvalid && rd_beat.last;

   assign rx_up       = (state_q == ST_UP);
   assign rx_error    = rx_error_q;
   assign overflow    = overflow_q;
   assign pause_req   = pause_q;
   assign local_pause = lpause_q;
   assign retrans_req = rreq_q;
   assign retrans_id  = rid_q;

endmodule

// File: doc/rifl_rx_deframer.md
RIFL_RX_DEFRAMER -- requirements
Module: rifl_rx_deframer

Interface
REQ-001 SHALL use one clock and asynchronous active-low reset: clk and rst_n.
REQ-002 SHALL have parameter FRAME_WIDTH, default 256, frame width in bits.
REQ-003 SHALL have parameter CRC_WIDTH, default 12, CRC field width; PAYLOAD_WIDTH = FRAME_WIDTH-4-CRC_WIDTH (default 240).
REQ-004 SHALL have parameter FRAME_ID_WIDTH, default 8, width of frame ID fields.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries, a power of 2 and at least 4.
REQ-006 SHALL have parameter PAUSE_HOLD, default 16, idle cycles before remote pause is released.
REQ-007 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, async active-low reset).
REQ-008 SHALL have s_frame_data (in, FRAME_WIDTH, descrambled frame: [FW-1:FW-4] header, [FW-5:CRC_WIDTH] payload, [CRC_WIDTH-1:0] CRC).
REQ-009 SHALL have s_frame_valid (in, 1, frame strobe, no backpressure) and s_frame_crc_ok (in, 1, upstream CRC check passed).
REQ-010 SHALL have s_aligned (in, 1, lane frame alignment achieved).
REQ-011 SHALL have m_axis_tdata (out, PAYLOAD_WIDTH), m_axis_tkeep (out, PAYLOAD_WIDTH/8), m_axis_tlast (out, 1), m_axis_tvalid (out, 1), m_axis_tready (in, 1).
REQ-012 SHALL have rx_up (out, 1, state UP), rx_error (out, 1, one-cycle error pulse), overflow (out, 1, sticky FIFO overflow).
REQ-013 SHALL have pause_req (out, 1, remote PAUSE in effect), local_pause (out, 1, FIFO count >= FIFO_DEPTH-2).
REQ-014 SHALL have retrans_req (out, 1, one-cycle pulse) and retrans_id (out, FRAME_ID_WIDTH, frame ID from the last RETRANS frame).

Function
REQ-015 Header decode SHALL be: 4'hA DATA; 4'hB DATA_LAST; 4'hC DATA_LAST_PARTIAL; 4'h5 IDLE; 4'h6 PAUSE; 4'h9 RETRANS; any other value SHALL be BAD.
REQ-016 A DATA frame SHALL push payload with tkeep all ones and tlast=0. A DATA_LAST frame SHALL push tkeep all ones and tlast=1.
REQ-017 A DATA_LAST_PARTIAL frame SHALL push with tlast=1. The count k = payload[7:0] SHALL be in 1..PAYLOAD_WIDTH/8-1, and tkeep SHALL have its top k bits set. The data SHALL be passed unmodified (MSB-aligned).
REQ-018 SHALL implement states DOWN, UP and ERROR. DOWN->UP on the first valid IDLE frame with crc_ok while s_aligned=1. Any state->DOWN when s_aligned=0, with priority over all other transitions.
REQ-019 In UP, a frame with crc_ok=0, a BAD header, or k outside 1..PAYLOAD_WIDTH/8-1 SHALL pulse rx_error the next cycle and move to ERROR. That frame SHALL NOT be pushed.
REQ-020 In ERROR, data frames SHALL be dropped. A crc_ok IDLE frame SHALL return the block to UP.
REQ-021 In DOWN, all frames SHALL be dropped, and no error, pause or retrans indication SHALL be raised.
REQ-022 PAUSE and RETRANS frames with crc_ok SHALL be acted on in both UP and ERROR states.
REQ-023 A crc_ok RETRANS frame SHALL register retrans_id = payload[FRAME_ID_WIDTH-1:0] and pulse retrans_req for 1 cycle, both one cycle after the frame.
REQ-024 A crc_ok PAUSE frame SHALL set pause_req the next cycle and reload a hold counter to PAUSE_HOLD. The counter SHALL decrement on each cycle without a PAUSE frame, and pause_req SHALL clear when it reaches 0.
REQ-025 Latency SHALL be 1 cycle from an accepted s_frame_valid to m_axis_tvalid when the FIFO is empty. The FIFO SHALL be first-word-fall-through.
REQ-026 Output SHALL follow AXI4-Stream rules: tdata, tkeep and tlast stable while tvalid=1 and tready=0; a pop occurs on tvalid&tready.
REQ-027 A push and a pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 A push when the FIFO is full with no simultaneous pop SHALL drop the frame, set overflow (sticky until reset) and pulse rx_error.
REQ-029 local_pause SHALL be a registered function of the FIFO count.

Reset
REQ-030 rst_n low SHALL asynchronously force: state DOWN, FIFO empty, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, rx_up=0, rx_error=0, overflow=0, pause_req=0, local_pause=0, retrans_req=0, retrans_id=0, hold counter=0.
REQ-031 Reset asserted mid-packet SHALL discard FIFO contents. After release, the block SHALL wait for the DOWN->UP condition.

Verification
REQ-032 Aligned, IDLE(crc_ok), then DATA, DATA, DATA_LAST_PARTIAL with k=5, tready=1 -> rx_up=1; 3 beats out, last with tlast=1 and tkeep=30'h3E000000.
REQ-033 tready=0, 9 DATA frames -> 8 held, 9th dropped, overflow=1, rx_error pulse; local_pause=1 from count 6.
REQ-034 UP, DATA with crc_ok=0 then DATA(ok) -> rx_error pulse, ERROR, both dropped; IDLE(ok) -> rx_up=1, next DATA pushed.
REQ-035 RETRANS with payload[7:0]=8'h3C -> retrans_req high 1 cycle, retrans_id=8'h3C; single PAUSE -> pause_req high exactly 17 cycles.
REQ-036 s_aligned drops while FIFO holds 3 beats -> DOWN, beats still drain; rst_n pulse mid-stream -> all outputs 0, FIFO empty.
